alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 1-bit logic ALU.
- Operates on WIDTH-bit operands with a 4-bit opcode: the original seven logic ops plus arithmetic, shift and pass ops.
- Produces status flags and keeps a count of accepted operations.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides and a one-entry output register.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, 16, width of the accepted-operation counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept a new operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  4  opcode
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  consumer accepts the result this cycle
result  output  WIDTH  registered result
flag_z  output  1  result == 0
flag_n  output  1  result MSB
flag_c  output  1  carry/borrow/shifted-out bit
flag_v  output  1  signed overflow
err  output  1  opcode illegal for this result
op_count  output  CNT_W  number of accepted operations, wraps modulo 2^CNT_W

Behaviour:
- Reset: rst_n low at a clk edge clears out_valid, result, all flags, err and op_count to 0.
  - Reset overrides any handshake in the same cycle.
  - A result held mid-transfer is discarded.
- in_ready = ~out_valid | out_ready (combinational). in_ready is low in any cycle where rst_n is low.
- Accept: in_valid & in_ready at a clk edge.
  - result/flags/err are loaded from a, b, op.
  - out_valid <= 1.
  - op_count increments.
  - Latency: 1 cycle from accept to out_valid.
- Drain: out_valid & out_ready with no accept clears out_valid. result keeps its last value.
- Simultaneous drain and accept loads the new result; out_valid stays 1. Full throughput is one operation per cycle.
- out_valid high and out_ready low: result, flags and err hold stable. in_ready is low.
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NOT a
  - 7 PASS a
  - 8 ADD a+b
  - 9 SUB a-b
  - 10 SHL a by b[log2(WIDTH)-1:0]
  - 11 SHR logical
  - 12 SRA arithmetic
  - 13–15 illegal
- Illegal opcode: result = 0, err = 1, flag_z = 1, all other flags 0. The operation is still accepted and counted.
- Flags:
  - Logic/pass ops: flag_c = flag_v = 0.
  - ADD: flag_c = carry out of bit WIDTH-1; flag_v = signed overflow.
  - SUB: flag_c = borrow (a < b unsigned); flag_v = signed overflow.
  - Shifts: flag_c = last bit shifted out; 0 when the shift amount is 0. flag_v = 0.
- Shift amount is taken modulo WIDTH.
- op_count wrap: at 2^CNT_W-1, the next accept gives 0. No flag is raised.

Optional Feature:
ALU_SAT_EN
- Defined: ADD and SUB saturate on signed overflow.
  - Positive overflow gives 0111…1; negative overflow gives 1000…0.
  - flag_v still reports the overflow.
  - flag_c is computed from the unsaturated sum/difference.
  - flag_z and flag_n reflect the saturated result.
- Undefined: ADD and SUB wrap modulo 2^WIDTH. No saturation logic is synthesised.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, result=0, op_count=0, in_ready=0. Release reset → in_ready=1.
- Logic ops (WIDTH=8): a=0xC3, b=0x5A, ops 0..7 back-to-back with out_ready=1:
  - results 0x42, 0xDB, 0xBD, 0x24, 0x99, 0x66, 0x3C, 0xC3
  - one result per cycle; op_count=8
- Arithmetic:
  - ADD 0x7F+0x01 → 0x80, v=1, c=0, n=1
  - ADD 0xFF+0x01 → 0x00, z=1, c=1
  - SUB 0x00-0x01 → 0xFF, c=1
  - With ALU_SAT_EN: ADD 0x7F+0x01 → 0x7F, v=1
- Shifts:
  - SHL 0x81 by 1 → 0x02, c=1
  - SRA 0x80 by 3 → 0xF0
  - SHR 0x01 by 9 (mod 8 = 1) → 0x00, z=1, c=1
- Backpressure: out_ready=0 for 3 cycles after one accept → in_ready=0 and result stable throughout. Raise out_ready with in_valid=1 → drain and accept in the same cycle; out_valid stays 1.
- Illegal opcode and wrap: op=14 → err=1, result=0, z=1, counted. With CNT_W=4, 16 accepts → op_count=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake/bus bundle for alu_pipe: operand side (in_*), result side (out_*), flags and counter.
// master = operand source + result consumer, slave = the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err, op_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err, op_count
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, status flags and an accept counter.
// Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_pipe_if.slave    bus
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;
  localparam logic [SH_W:0]    SH_LIM  = (SH_W + 1)'(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NAND = 4'd2,
    OP_NOR  = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NOT  = 4'd6,
    OP_PASS = 4'd7,
    OP_ADD  = 4'd8,
    OP_SUB  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_SRA  = 4'd12
  } op_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_in_ready;
  logic             w_accept;
  logic [SH_W:0]    w_sh_ext;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sra;
  logic             w_add_v;
  logic             w_sub_v;
  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  assign w_in_ready = rst_n & (~r_out_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Shift amount reduced modulo WIDTH (a no-op fold when WIDTH is a power of two).
  assign w_sh_ext = {1'b0, bus.b[SH_W-1:0]};
  assign w_sh     = (w_sh_ext >= SH_LIM) ? SH_W'(w_sh_ext - SH_LIM) : w_sh_ext[SH_W-1:0];

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  // One guard bit catches the last bit shifted out on either side.
  assign w_shl  = {1'b0, bus.a} << w_sh;
  assign w_shr  = {bus.a, 1'b0} >> w_sh;
  assign w_sra  = $unsigned($signed({bus.a, 1'b0}) >>> w_sh);

  assign w_add_v = (bus.a[MSB] == bus.b[MSB]) & (w_sum[MSB] != bus.a[MSB]);
  assign w_sub_v = (bus.a[MSB] != bus.b[MSB]) & (w_diff[MSB] != bus.a[MSB]);
  // On overflow the true result has the sign of operand a for both ADD and SUB.
  assign w_sat   = bus.a[MSB] ? MSB_ONE : ~MSB_ONE;

  // Next result, carry, overflow and error for the presented operation.
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (bus.op)
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_NAND: w_res = ~(bus.a & bus.b);
      OP_NOR:  w_res = ~(bus.a | bus.b);
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_XNOR: w_res = ~(bus.a ^ bus.b);
      OP_NOT:  w_res = ~bus.a;
      OP_PASS: w_res = bus.a;
      OP_ADD: begin
`ifdef ALU_SAT_EN
        w_res = w_add_v ? w_sat : w_sum[WIDTH-1:0];
`else
        w_res = w_sum[WIDTH-1:0];
`endif
        w_c = w_sum[WIDTH];
        w_v = w_add_v;
      end
      OP_SUB: begin
`ifdef ALU_SAT_EN
        w_res = w_sub_v ? w_sat : w_diff[WIDTH-1:0];
`else
        w_res = w_diff[WIDTH-1:0];
`endif
        w_c = w_diff[WIDTH];
        w_v = w_sub_v;
      end
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      default: begin
        w_res = {WIDTH{1'b0}};
        w_err = 1'b1;
      end
    endcase
  end

  // Output register, valid bit and accept counter; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_err       <= 1'b0;
      r_op_count  <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_flag_z    <= (w_res == {WIDTH{1'b0}});
      r_flag_n    <= w_res[MSB];
      r_flag_c    <= w_c;
      r_flag_v    <= w_v;
      r_err       <= w_err;
      r_op_count  <= r_op_count + {{(CNT_W - 1){1'b0}}, 1'b1};
    end else if (r_out_valid & bus.out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_n    = r_flag_n;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_v    = r_flag_v;
  assign bus.err       = r_err;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8, CNT_W=4): expected results queued on drive, compared on transfer.
module tb_alu_pipe;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   exp_cnt = 0;
  int   p0;
  exp_t sbq[$];
  exp_t mon_e;
  exp_t last_e;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

  alu_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    exp_t e;
    int ua, ub, sa, sbv, s, r, sh;
    e = '0;
    e.op = op;
    ua = int'(a);
    ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sbv = b[7] ? ub - 256 : ub;
    sh = ub % 8;
    r = 0;
    case (op)
      4'd0: r = ua & ub;
      4'd1: r = ua | ub;
      4'd2: r = (~(ua & ub)) & 255;
      4'd3: r = (~(ua | ub)) & 255;
      4'd4: r = ua ^ ub;
      4'd5: r = (~(ua ^ ub)) & 255;
      4'd6: r = (~ua) & 255;
      4'd7: r = ua;
      4'd8: begin
        r = (ua + ub) & 255;
        e.c = ((ua + ub) > 255);
        s = sa + sbv;
        e.v = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
        if (e.v) r = (s > 127) ? 127 : 128;
`endif
      end
      4'd9: begin
        r = (ua - ub) & 255;
        e.c = (ua < ub);
        s = sa - sbv;
        e.v = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
        if (e.v) r = (s > 127) ? 127 : 128;
`endif
      end
      4'd10: begin
        r = (ua << sh) & 255;
        e.c = (sh != 0) && (((ua >> (8 - sh)) & 1) != 0);
      end
      4'd11: begin
        r = ua >> sh;
        e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
      end
      4'd12: begin
        r = (sa >>> sh) & 255;
        e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
      end
      default: begin
        r = 0;
        e.err = 1'b1;
      end
    endcase
    e.res = r[7:0];
    e.z = (r == 0);
    e.n = r[7];
    return e;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    last_e = model(a, b, op);
    sbq.push_back(last_e);
    exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string tag);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, sbq.size(), 0);
  endtask

  // Result monitor: a transfer happens at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("sb_nonempty", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        pops++;
        chk($sformatf("res_op%0d", mon_e.op), bus.result, mon_e.res);
        chk($sformatf("flags_zncve_op%0d", mon_e.op),
            {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.err},
            {mon_e.z, mon_e.n, mon_e.c, mon_e.v, mon_e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] va [0:10];
    logic [7:0] vb [0:10];
    logic [3:0] vo [0:10];
    va = '{8'h7F, 8'hFF, 8'h00, 8'h81, 8'h80, 8'h01, 8'h05, 8'h80, 8'h80, 8'hC3, 8'h40};
    vb = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h03, 8'h09, 8'h07, 8'h01, 8'hFF, 8'h00, 8'hC0};
    vo = '{4'd8,  4'd8,  4'd9,  4'd10, 4'd12, 4'd11, 4'd9,  4'd9,  4'd9,  4'd10, 4'd9};

    // Reset with a pending request: nothing may be accepted.
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.op = 4'd8;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.err}, 0);
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Logic ops back to back, one result per cycle.
    p0 = pops;
    for (int i = 0; i < 8; i++) send(8'hC3, 8'h5A, 4'(i));
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("logic_throughput", pops - p0, 8);
    chk("logic_op_count", bus.op_count, 8);
    @(posedge clk);
    #1;

    // Arithmetic, shift and illegal-opcode vectors, then random traffic.
    for (int i = 0; i < 11; i++) send(va[i], vb[i], vo[i]);
    send(8'h12, 8'h34, 4'd14);
    send(8'hFF, 8'hFF, 4'd13);
    send(8'h00, 8'h00, 4'd15);
    for (int i = 0; i < 24; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_op_count", bus.op_count, 32'(exp_cnt % 16));
    drain_check("sb_drained_arith");
    @(negedge clk);
    chk("drain_out_valid", bus.out_valid, 0);
    chk("drain_result_held", bus.result, 32'(last_e.res));
    @(posedge clk);
    #1;

    // Backpressure: result must stay put while the consumer stalls.
    bus.out_ready = 1'b0;
    send(8'h10, 8'h20, 4'd8);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_result", bus.result, 32'h30);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'h33, 8'h11, 4'd9);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain_accept_valid", bus.out_valid, 1);
    chk("bp_drain_accept_result", bus.result, 32'h22);
    drain_check("sb_drained_bp");

    // Counter wrap: 16 accepts from reset on a 4-bit counter.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 12)));
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_op_count", bus.op_count, 0);
    drain_check("sb_drained_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
